// File: rtl/clock_pkg.sv
// Shared types for the clock/time counter: FSM mode encoding and BCD digit.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } mode_t;

   typedef logic [3:0] bcd_t;

endpackage

// File: rtl/clock_time_counter_if.sv
// Key inputs and display outputs of the clock; slave = clock core, master = keypad/display side.
interface clock_time_counter_if;
   import clock_pkg::*;

   logic       key_mode;
   logic       key_inc;
   bcd_t       digit3;
   bcd_t       digit2;
   bcd_t       digit1;
   bcd_t       digit0;
   logic [3:0] digit_en;
   logic [3:0] dot_en;
   logic       sec_tick;

   modport slave (
      input  key_mode, key_inc,
      output digit3, digit2, digit1, digit0, digit_en, dot_en, sec_tick
   );

   modport master (
      output key_mode, key_inc,
      input  digit3, digit2, digit1, digit0, digit_en, dot_en, sec_tick
   );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MOD-1 -> 00; carry flags the wrapping increment.
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter int MOD = 60
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output bcd_t tens,
   output bcd_t units,
   output logic carry
);
   localparam bcd_t MAX_T = bcd_t'((MOD - 1) / 10);
   localparam bcd_t MAX_U = bcd_t'((MOD - 1) % 10);

   bcd_t tens_q, tens_d;
   bcd_t units_q, units_d;

   always_comb begin
      tens_d  = tens_q;
      units_d = units_q;
      carry   = inc && (tens_q == MAX_T) && (units_q == MAX_U);
      if (clr) begin
         tens_d  = '0;
         units_d = '0;
      end else if (inc) begin
         if (carry) begin
            tens_d  = '0;
            units_d = '0;
         end else if (units_q == 4'd9) begin
            tens_d  = tens_q + 4'd1;
            units_d = '0;
         end else begin
            units_d = units_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tens_q  <= '0;
         units_q <= '0;
      end else begin
         tens_q  <= tens_d;
         units_q <= units_d;
      end
   end

   assign tens  = tens_q;
   assign units = units_q;

endmodule

// File: rtl/clock_time_counter.sv
// HH:MM clock with second prescaler, two-key set mode and registered display drive.
module clock_time_counter
   import clock_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   clock_time_counter_if.slave  bus
);
   localparam int              PW   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]   LAST = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0]   HALF = PW'(CLK_HZ / 2);

   logic [PW-1:0] presc_q, presc_d;
   mode_t         state_q, state_d;

   logic km_s1_q, km_s1_d, km_s2_q, km_s2_d, km_prev_q, km_prev_d;
   logic ki_s1_q, ki_s1_d, ki_s2_q, ki_s2_d, ki_prev_q, ki_prev_d;

   bcd_t       digit3_q, digit3_d, digit2_q, digit2_d;
   bcd_t       digit1_q, digit1_d, digit0_q, digit0_d;
   logic [3:0] digit_en_q, digit_en_d;
   logic [3:0] dot_en_q, dot_en_d;
   logic       sec_tick_q, sec_tick_d;

   logic mode_pulse, inc_pulse, tick, half_phase, run, exit_set;
   logic sec_inc, min_inc, hr_inc;
   logic sec_carry, min_carry, hr_carry;
   bcd_t sec_tens, sec_units, min_tens, min_units, hr_tens, hr_units;
   logic sec_unused;

   assign mode_pulse = km_s2_q & ~km_prev_q;
   assign inc_pulse  = ki_s2_q & ~ki_prev_q;
   assign tick       = (presc_q == LAST);
   assign half_phase = (presc_q < HALF);
   assign run        = (state_q == RUN);
   assign exit_set   = mode_pulse && (state_q == SET_MIN);

   // Carries only ripple while running, so a set-mode wrap never touches the next field.
   assign sec_inc = run && tick;
   assign min_inc = (run && sec_carry) || ((state_q == SET_MIN) && inc_pulse && !mode_pulse);
   assign hr_inc  = (run && min_carry) || ((state_q == SET_HOUR) && inc_pulse && !mode_pulse);

   bcd_mod_counter #(.MOD(60)) u_sec (
      .clk(clk), .rst_n(rst_n), .inc(sec_inc), .clr(exit_set),
      .tens(sec_tens), .units(sec_units), .carry(sec_carry)
   );
   bcd_mod_counter #(.MOD(60)) u_min (
      .clk(clk), .rst_n(rst_n), .inc(min_inc), .clr(1'b0),
      .tens(min_tens), .units(min_units), .carry(min_carry)
   );
   bcd_mod_counter #(.MOD(24)) u_hr (
      .clk(clk), .rst_n(rst_n), .inc(hr_inc), .clr(1'b0),
      .tens(hr_tens), .units(hr_units), .carry(hr_carry)
   );

   assign sec_unused = ^{sec_tens, sec_units, hr_carry};

   always_comb begin
      km_s1_d   = bus.key_mode;
      km_s2_d   = km_s1_q;
      km_prev_d = km_s2_q;
      ki_s1_d   = bus.key_inc;
      ki_s2_d   = ki_s1_q;
      ki_prev_d = ki_s2_q;

      state_d = state_q;
      if (mode_pulse) begin
         case (state_q)
            RUN:      state_d = SET_HOUR;
            SET_HOUR: state_d = SET_MIN;
            SET_MIN:  state_d = RUN;
            default:  state_d = RUN;
         endcase
      end

      presc_d = (tick || exit_set) ? '0 : presc_q + PW'(1);
   end

   // Display drive; sec_tick is aligned with the prescaler's last count.
   always_comb begin
      digit3_d   = hr_tens;
      digit2_d   = hr_units;
      digit1_d   = min_tens;
      digit0_d   = min_units;
      sec_tick_d = (presc_d == LAST);
      digit_en_d = 4'b1111;
      dot_en_d   = 4'b0000;
      case (state_q)
         RUN: begin
            digit_en_d = {(hr_tens != 4'd0), 3'b111};
            dot_en_d   = {1'b0, half_phase, 2'b00};
         end
         SET_HOUR: digit_en_d = {half_phase, half_phase, 2'b11};
         SET_MIN:  digit_en_d = {2'b11, half_phase, half_phase};
         default:  digit_en_d = 4'b1111;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q    <= '0;
         state_q    <= RUN;
         km_s1_q    <= 1'b0;
         km_s2_q    <= 1'b0;
         km_prev_q  <= 1'b0;
         ki_s1_q    <= 1'b0;
         ki_s2_q    <= 1'b0;
         ki_prev_q  <= 1'b0;
         digit3_q   <= '0;
         digit2_q   <= '0;
         digit1_q   <= '0;
         digit0_q   <= '0;
         digit_en_q <= 4'b0111;
         dot_en_q   <= 4'b0000;
         sec_tick_q <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         state_q    <= state_d;
         km_s1_q    <= km_s1_d;
         km_s2_q    <= km_s2_d;
         km_prev_q  <= km_prev_d;
         ki_s1_q    <= ki_s1_d;
         ki_s2_q    <= ki_s2_d;
         ki_prev_q  <= ki_prev_d;
         digit3_q   <= digit3_d;
         digit2_q   <= digit2_d;
         digit1_q   <= digit1_d;
         digit0_q   <= digit0_d;
         digit_en_q <= digit_en_d;
         dot_en_q   <= dot_en_d;
         sec_tick_q <= sec_tick_d;
      end
   end

   assign bus.digit3   = digit3_q;
   assign bus.digit2   = digit2_q;
   assign bus.digit1   = digit1_q;
   assign bus.digit0   = digit0_q;
   assign bus.digit_en = digit_en_q;
   assign bus.dot_en   = dot_en_q;
   assign bus.sec_tick = sec_tick_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter: directed scenarios plus random key traffic against a time-of-day model.
module tb_clock_time_counter;
   import clock_pkg::*;

   localparam int C = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   cyc_n = 0;

   // model: mode 0=run 1=set hour 2=set min; p = prescaler; time as h/m/s
   int         m_mode, m_p, m_h, m_m, m_s;
   logic [15:0] e_dig;
   logic [3:0]  e_en, e_dot;
   logic        e_tick;

   clock_time_counter_if bus ();

   clock_time_counter #(.CLK_HZ(C)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_mode = 0; m_p = 0; m_h = 0; m_m = 0; m_s = 0;
      e_dig = 16'h0000; e_en = 4'b0111; e_dot = 4'b0000; e_tick = 1'b0;
   endtask

   task automatic model_step(input bit mev, input bit iev);
      int tot;
      bit tk, half, leave;
      tk   = (m_p == C - 1);
      half = (m_p < C / 2);
      e_dig = {4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10)};
      case (m_mode)
         0: begin e_en = {(m_h >= 10), 3'b111}; e_dot = {1'b0, half, 2'b00}; end
         1: begin e_en = {half, half, 2'b11};   e_dot = 4'b0000; end
         default: begin e_en = {2'b11, half, half}; e_dot = 4'b0000; end
      endcase
      if (m_mode == 0 && tk) begin
         tot = (m_s + 60 * m_m + 3600 * m_h + 1) % 86400;
         m_h = tot / 3600; m_m = (tot / 60) % 60; m_s = tot % 60;
      end
      leave = mev && (m_mode == 2);
      if (mev) m_mode = (m_mode + 1) % 3;
      else if (iev && m_mode == 1) m_h = (m_h + 1) % 24;
      else if (iev && m_mode == 2) m_m = (m_m + 1) % 60;
      if (leave) m_s = 0;
      m_p = leave ? 0 : (m_p + 1) % C;
      e_tick = (m_p == C - 1);
   endtask

   task automatic check(input string tag);
      logic [15:0] dig;
      dig = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
      tests++;
      assert (dig === e_dig) else begin
         fails++; $error("FAIL %s cyc %0d digits got %h exp %h", tag, cyc_n, dig, e_dig);
      end
      tests++;
      assert (bus.digit_en === e_en) else begin
         fails++; $error("FAIL %s cyc %0d digit_en got %b exp %b", tag, cyc_n, bus.digit_en, e_en);
      end
      tests++;
      assert (bus.dot_en === e_dot) else begin
         fails++; $error("FAIL %s cyc %0d dot_en got %b exp %b", tag, cyc_n, bus.dot_en, e_dot);
      end
      tests++;
      assert (bus.sec_tick === e_tick) else begin
         fails++; $error("FAIL %s cyc %0d sec_tick got %b exp %b", tag, cyc_n, bus.sec_tick, e_tick);
      end
   endtask

   task automatic cyc(input string tag, input bit mev, input bit iev);
      @(posedge clk);
      model_step(mev, iev);
      cyc_n++;
      #1;
      check(tag);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      @(posedge clk);
      model_reset();
      cyc_n++;
      #1;
      check(tag);
      rst_n = 1'b1;
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0);
   endtask

   // A raw press becomes an internal pulse acting on the third edge after it.
   task automatic press(input string tag, input bit m, input bit i);
      bus.key_mode = m;
      bus.key_inc  = i;
      cyc(tag, 1'b0, 1'b0);
      cyc(tag, 1'b0, 1'b0);
      cyc(tag, m, i);
      bus.key_mode = 1'b0;
      bus.key_inc  = 1'b0;
      idle(tag, 3);
   endtask

   initial begin
      int r;
      bus.key_mode = 1'b0;
      bus.key_inc  = 1'b0;
      model_reset();

      do_reset("reset");
      do_reset("reset");
      idle("first_tick", 6);
      idle("run60", 60 * C);

      do_reset("reset2");
      press("to_set_hour", 1'b1, 1'b0);
      for (int k = 0; k < 23; k++) press("inc_hour", 1'b0, 1'b1);
      press("to_set_min", 1'b1, 1'b0);
      for (int k = 0; k < 59; k++) press("inc_min", 1'b0, 1'b1);
      press("exit_set", 1'b1, 1'b0);
      idle("wrap_day", 62 * C);

      press("to_set_hour2", 1'b1, 1'b0);
      press("mode_and_inc", 1'b1, 1'b1);
      for (int k = 0; k < 37; k++) press("inc_min37", 1'b0, 1'b1);
      do_reset("reset_in_set");
      idle("after_reset", 3);

      press("to_set_hour3", 1'b1, 1'b0);
      press("inc_hour3", 1'b0, 1'b1);
      press("to_set_min3", 1'b1, 1'b0);
      idle("hold_set_min", 2 * C);
      press("exit_set3", 1'b1, 1'b0);
      idle("after_exit", 3 * C);

      for (int it = 0; it < 250; it++) begin
         r = $urandom_range(0, 19);
         if (r < 6)       idle("rnd_idle", $urandom_range(1, 12));
         else if (r < 10) press("rnd_mode", 1'b1, 1'b0);
         else if (r < 17) press("rnd_inc", 1'b0, 1'b1);
         else if (r < 19) press("rnd_both", 1'b1, 1'b1);
         else             do_reset("rnd_reset");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/clock_time_counter.md
CLOCK_TIME_COUNTER -- requirements
Module: clock_time_counter

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz; SHALL be an even number >= 4.
REQ-002 clk  input  1  system clock; the block SHALL use one clock only.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 key_mode  input  1  raw pushbutton level, active-high, asynchronous to clk.
REQ-005 key_inc  input  1  raw pushbutton level, active-high, asynchronous to clk.
REQ-006 digit3..digit0  output  4 each  BCD values: hour tens, hour units, minute tens, minute units.
REQ-007 digit_en  output  4  per-digit enable for the downstream 7-segment decoders; bit i drives digit i.
REQ-008 dot_en  output  4  per-digit decimal-point enable; bit i drives digit i.
REQ-009 sec_tick  output  1  one-cycle pulse each elapsed second.

Function
REQ-010 The prescaler SHALL count 0..CLK_HZ-1 and wrap, advancing every cycle in all states.
REQ-011 sec_tick SHALL be 1 for exactly the cycle in which the prescaler equals CLK_HZ-1.
REQ-012 half_phase SHALL be 1 while the prescaler is < CLK_HZ/2, and 0 otherwise.
REQ-013 Each key SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; a press therefore yields one internal pulse, 3 cycles after the raw edge.
REQ-014 Time SHALL be held as a BCD seconds pair (0..59), a BCD minutes pair (0..59) and a BCD hours pair (0..23).
REQ-015 Every BCD digit SHALL stay in range at all times; values A..F SHALL never appear.
REQ-016 In RUN, sec_tick SHALL increment the seconds, with ripple carry:
  - 59 s -> 0 s, with minutes +1;
  - 59 min -> 0 min, with hours +1;
  - 23 h -> 00 h.
REQ-017 The FSM SHALL have the states RUN, SET_HOUR and SET_MIN.
REQ-018 A mode pulse SHALL move the FSM RUN -> SET_HOUR -> SET_MIN -> RUN.
REQ-019 Time SHALL NOT advance on sec_tick in SET_HOUR or SET_MIN.
REQ-020 An inc pulse in SET_HOUR SHALL increment hours modulo 24; 23 -> 00 SHALL leave the minutes unchanged.
REQ-021 An inc pulse in SET_MIN SHALL increment minutes modulo 60; 59 -> 00 SHALL leave the hours unchanged.
REQ-022 An inc pulse in RUN SHALL be ignored.
REQ-023 The SET_MIN -> RUN transition SHALL clear seconds to 00 and reset the prescaler to 0 in the same cycle.
REQ-024 If mode and inc pulses fall in the same cycle, mode SHALL win and inc SHALL be discarded.
REQ-025 If sec_tick coincides with a mode pulse out of RUN, the tick increment SHALL be applied first, then the state SHALL change.
REQ-026 In RUN, digit_en SHALL be 4'b1111, except that digit_en[3] SHALL be 0 when the hour tens digit is 0 (leading-zero blanking).
REQ-027 In SET_HOUR, digit_en SHALL be {half_phase, half_phase, 1, 1}, with no leading-zero blanking.
REQ-028 In SET_MIN, digit_en SHALL be {1, 1, half_phase, half_phase}.
REQ-029 In RUN, dot_en SHALL be {1'b0, half_phase, 2'b00}, giving a blinking colon after the hour units; in the set states dot_en SHALL be 4'b0000.
REQ-030 All outputs SHALL be registered, one cycle after the state or counter change that drives them.

Reset
REQ-031 While rst_n = 0 at a clk edge, the block SHALL load:
  - state RUN;
  - prescaler 0;
  - time 00:00:00;
  - synchronizer and edge-detect flops 0.
REQ-032 Output reset values SHALL be:
  - digits 0;
  - digit_en 4'b0111;
  - dot_en 4'b0000;
  - sec_tick 0.
REQ-033 A reset asserted mid-SET SHALL return the FSM to RUN and discard the partially set time.

Structure
REQ-034 A shared package clock_pkg SHALL hold the FSM state enum (mode_t) and the BCD digit typedef (bcd_t, 4 bits).
REQ-035 A single sub-module bcd_mod_counter (parameters for the modulus, inputs inc, outputs tens, units and carry) SHALL implement each of the seconds, minutes and hours pairs.
REQ-036 The synchronizer and edge detector SHALL be inline logic, not a separate module.

Verification (CLK_HZ = 4)
REQ-037 Reset release -> digits 0,0,0,0; digit_en 0111; dot_en 0000; first sec_tick on the 4th cycle after reset release.
REQ-038 Run 60 ticks from reset -> digits 0,0,0,1; seconds = 00; dot_en[2] toggles with half_phase, period 4 cycles.
REQ-039 Set mode, 23 hour incs, mode, 59 min incs, mode; then 60 ticks -> display 23:59 then 00:00; digit_en[3] = 0 after the wrap.
REQ-040 In SET_HOUR, mode and inc pulsed in the same cycle -> FSM enters SET_MIN and hours are unchanged.
REQ-041 Assert rst_n = 0 for one cycle while in SET_MIN with minutes = 37 -> FSM in RUN and time 00:00:00 on the next cycle.
REQ-042 Wait 2 ticks in SET_MIN, then exit -> seconds = 00 and the prescaler restarts; the next sec_tick comes exactly CLK_HZ cycles after exit.
